// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg -- definitions shared by the load/store unit and the memory model.
//
// Contents:
//   MEM_BYTES_DEFAULT   default size of the byte-addressable memory
//   BYTE/HALF_WORD/WORD access-size encodings on req_size / mem_size
//   IDLE/ACCESS/SPLIT/RESP  load/store unit FSM state encoding
//   size_nbytes()       number of bytes touched by an access size
//   size_misaligned()   alignment test for an access size and address
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_BYTES_DEFAULT = 128;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] SPLIT  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // The illegal encoding 11 reports one byte; it is rejected separately.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            HALF_WORD: size_nbytes = 3'd2;
            WORD:      size_nbytes = 3'd4;
            default:   size_nbytes = 3'd1;
        endcase
    endfunction

    function automatic logic size_misaligned(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        case (size)
            HALF_WORD: size_misaligned = addr_lo[0];
            WORD:      size_misaligned = (addr_lo != 2'b00);
            default:   size_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_extend.sv
// ---------------------------------------------------------------------------
// mem_lsu_extend -- sign/zero extension of a little-endian assembled load.
//
// Ports:
//   data    in  32  assembled bytes, byte 0 in data[7:0]
//   size    in  2   access size (BYTE/HALF_WORD/WORD)
//   sext    in  1   1 = sign-extend, 0 = zero-extend
//   result  out 32  extended load value
// ---------------------------------------------------------------------------
module mem_lsu_extend
    import mem_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] result
);

    always_comb begin
        case (size)
            BYTE:      result = {{24{sext & data[7]}}, data[7:0]};
            HALF_WORD: result = {{16{sext & data[15]}}, data[15:0]};
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu -- single-outstanding load/store unit in front of a byte memory
// with combinational read and falling-edge write.
//
// Build option: define LSU_MISALIGN_SPLIT_EN to execute misaligned half/word
// accesses as a sequence of byte accesses; otherwise they are rejected.
//
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready handshake; req_addr, req_wdata, req_we,
//     req_size (10 word, 01 half, 00 byte), req_sext
//   resp_valid (one-cycle pulse), resp_rdata, resp_err
//   mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex  -> memory
//   mem_data_out                                             <- memory
// ---------------------------------------------------------------------------
module mem_lsu
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_wr_en,
    output logic [1:0]  mem_size,
    output logic        mem_sz_ex,
    input  logic [31:0] mem_data_out
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic [1:0]  state;
    logic [1:0]  cnt;
    logic        err_r;

    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic        we_p0;
    logic [1:0]  size_p0;
    logic        sext_p0;
    logic [31:0] asm_p1;
    logic [31:0] result_p1;

    logic        accept;
    logic [32:0] req_last;
    logic        req_reject;
    logic        req_misaligned;
    logic        split_last;
    logic [31:0] asm_nxt;
    logic [31:0] ext_data;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Last byte touched, in 33 bits so an address near 2^32 cannot wrap
    // around and slip under the memory size.
    assign req_last       = {1'b0, req_addr} + {30'b0, size_nbytes(req_size)} - 33'd1;
    assign req_misaligned = size_misaligned(req_size, req_addr[1:0]);
    assign req_reject     = (req_size == 2'b11)
                          || (req_last >= 33'(MEM_BYTES))
                          || (req_misaligned && !SPLIT_EN);

    // Split sequences are only ever half (2 bytes) or word (4 bytes).
    assign split_last = (cnt == ((size_p0 == WORD) ? 2'd3 : 2'd1));

    always_comb begin
        asm_nxt = asm_p1;
        asm_nxt[{cnt, 3'b000} +: 8] = mem_data_out[7:0];
    end

    mem_lsu_extend u_extend (
        .data   (asm_nxt),
        .size   (size_p0),
        .sext   (sext_p0),
        .result (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        err_r <= req_reject;
                        cnt   <= 2'd0;
                        if (req_reject)          state <= RESP;
                        else if (req_misaligned) state <= SPLIT;
                        else                     state <= ACCESS;
                    end
                end
                ACCESS: state <= RESP;
                SPLIT: begin
                    cnt <= cnt + 2'd1;
                    if (split_last) state <= RESP;
                end
                default: begin
                    state <= IDLE;
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    // Stage 0: request capture.  Stage 1: load result capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            we_p0    <= req_we;
            size_p0  <= req_size;
            sext_p0  <= req_sext;
        end
        case (state)
            ACCESS: result_p1 <= we_p0 ? 32'd0 : mem_data_out;
            SPLIT: begin
                asm_p1 <= asm_nxt;
                if (split_last) result_p1 <= we_p0 ? 32'd0 : ext_data;
            end
            default: ;
        endcase
    end

    // Memory port is quiet outside ACCESS/SPLIT so the falling-edge write
    // can only land inside an active access; reset forces IDLE at once.
    always_comb begin
        mem_address = 32'd0;
        mem_data_in = 32'd0;
        mem_wr_en   = 1'b0;
        mem_size    = BYTE;
        mem_sz_ex   = 1'b0;
        case (state)
            ACCESS: begin
                mem_address = addr_p0;
                mem_data_in = wdata_p0;
                mem_wr_en   = we_p0;
                mem_size    = size_p0;
                mem_sz_ex   = sext_p0;
            end
            SPLIT: begin
                mem_address = addr_p0 + {30'b0, cnt};
                mem_data_in = {24'b0, wdata_p0[{cnt, 3'b000} +: 8]};
                mem_wr_en   = we_p0;
            end
            default: ;
        endcase
    end

    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_r;
    assign resp_rdata = (resp_valid && !err_r) ? result_p1 : 32'd0;

endmodule
